rr_tdm_mult: RTL and testbench

- N-channel time-division multiply engine.
- Each channel has a valid/ready ingress with a 1-entry holding register.
- A work-conserving round-robin arbiter grants one occupied channel per clock. It skips idle channels rather than rotating blindly.
- The granted sample is multiplied by that channel's coefficient, taken from a per-channel incrementer, decrementer or constant. The pipelined product leaves tagged with its channel ID.
- Sits between the input buffers and the output path of the TDM datapath, replacing the fixed two-way rotation.

---
 rtl/rr_tdm_pkg.sv | 20 ++
 rtl/rr_grant_arbiter.sv | 43 ++++
 rtl/rr_tdm_mult.sv | 128 ++++++++++++
 tb/tb_rr_tdm_mult.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_tdm_pkg.sv
// rr_tdm_pkg: shared types, default widths and width helper for the TDM multiply engine
package rr_tdm_pkg;

    typedef enum logic [1:0] {
        COEF_INCR      = 2'd0,
        COEF_DECR      = 2'd1,
        COEF_CONST     = 2'd2,
        COEF_CONST_ALT = 2'd3
    } coef_mode_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_COEF_WIDTH   = 8;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_MULT_LATENCY = 3;

    function automatic int prod_width(input int dw, input int cw);
        return dw + cw;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: work-conserving round-robin arbiter, one-hot grant plus index.
//   clk, rst       : clock, synchronous active-high reset
//   req_i          : request vector
//   grant_o        : one-hot grant
//   grant_idx_o    : index of the granted requester
//   grant_valid_o  : some requester was granted
module rr_grant_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 grant_valid_o
);
    localparam int W = $clog2(N);

    logic [W-1:0] ptr_q;
    logic [W-1:0] idx;

    // Search starts just past the last winner, so the last winner has lowest priority.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(ptr_q) + i) % N);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= W'(N - 1);
        else if (grant_valid_o) ptr_q <= grant_idx_o;
    end

endmodule

// File: rtl/rr_tdm_mult.sv
// rr_tdm_mult: N-channel round-robin time-division multiplier with per-channel coefficient generators.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid/in_ready/in_data : per-channel ingress, one holding register each
//   coef_mode   : per-channel 2-bit mode (INCR, DECR, CONST, CONST)
//   coef_const  : per-channel constant coefficient
//   out_valid/out_ch/out_data : one-cycle product strobe tagged with its channel
//   busy        : any holding register or pipeline stage occupied
module rr_tdm_mult
    import rr_tdm_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH   = DEF_COEF_WIDTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                in_valid,
    output logic [NUM_CH-1:0]                in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     in_data,
    input  logic [2*NUM_CH-1:0]              coef_mode,
    input  logic [NUM_CH*COEF_WIDTH-1:0]     coef_const,
    output logic                             out_valid,
    output logic [$clog2(NUM_CH)-1:0]        out_ch,
    output logic [DATA_WIDTH+COEF_WIDTH-1:0] out_data,
    output logic                             busy
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int PW   = prod_width(DATA_WIDTH, COEF_WIDTH);

    logic [NUM_CH-1:0]     hold_valid_q;
    logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
    logic [COEF_WIDTH-1:0] incr_q [NUM_CH];
    logic [COEF_WIDTH-1:0] decr_q [NUM_CH];
    logic [NUM_CH-1:0]     grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  any_grant;
    coef_mode_e            mode;
    logic [COEF_WIDTH-1:0] coef;
    logic [DATA_WIDTH-1:0] a_d;

    logic [DATA_WIDTH-1:0] a_q;
    logic [COEF_WIDTH-1:0] b_q;
    logic [CH_W-1:0]       op_ch_q;
    logic                  op_v_q;
    logic [PW-1:0]         p_q  [MULT_LATENCY];
    logic [CH_W-1:0]       ch_q [MULT_LATENCY];
    logic [MULT_LATENCY-1:0] v_q;

    rr_grant_arbiter #(.N(NUM_CH)) u_arb (
        .clk           (clk),
        .rst           (rst),
        .req_i         (hold_valid_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (any_grant)
    );

    // A granted hold empties this edge, so it may be refilled in the same cycle.
    assign in_ready = rst ? '0 : (~hold_valid_q | grant);

    // Operand and coefficient selection driven by the one-hot grant.
    always_comb begin
        mode = COEF_CONST;
        coef = '0;
        a_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                mode = coef_mode_e'(coef_mode[2*c +: 2]);
                coef = mode == COEF_INCR ? incr_q[c] :
                       mode == COEF_DECR ? decr_q[c] : coef_const[c*COEF_WIDTH +: COEF_WIDTH];
                a_d  = hold_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                hold_valid_q[c] <= 1'b0;
                incr_q[c]       <= '0;
                decr_q[c]       <= '1;
            end else begin
                if (in_valid[c] && in_ready[c]) begin
                    hold_valid_q[c] <= 1'b1;
                    hold_q[c]       <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
                end else if (grant[c]) begin
                    hold_valid_q[c] <= 1'b0;
                end
                if (grant[c] && mode == COEF_INCR) incr_q[c] <= incr_q[c] + 1'b1;
                if (grant[c] && mode == COEF_DECR) decr_q[c] <= decr_q[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= coef;
        op_ch_q <= grant_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_v_q <= 1'b0;
            v_q    <= '0;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                p_q[s]  <= '0;
                ch_q[s] <= '0;
            end
        end else begin
            op_v_q  <= any_grant;
            v_q[0]  <= op_v_q;
            p_q[0]  <= PW'(a_q) * PW'(b_q);
            ch_q[0] <= op_ch_q;
            for (int s = 1; s < MULT_LATENCY; s++) begin
                v_q[s]  <= v_q[s-1];
                p_q[s]  <= p_q[s-1];
                ch_q[s] <= ch_q[s-1];
            end
        end
    end

    assign out_valid = v_q[MULT_LATENCY-1];
    assign out_ch    = ch_q[MULT_LATENCY-1];
    assign out_data  = p_q[MULT_LATENCY-1];
    assign busy      = |hold_valid_q || op_v_q || |v_q;

endmodule

// File: tb/tb_rr_tdm_mult.sv
// tb_rr_tdm_mult: self-checking bench for rr_tdm_mult (scoreboard plus vector table)
module tb_rr_tdm_mult;
    import rr_tdm_pkg::*;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int PW = DW + CW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC-1:0]   in_valid;
    logic [NC-1:0]   in_ready;
    logic [NC*DW-1:0] in_data;
    logic [2*NC-1:0] coef_mode;
    logic [NC*CW-1:0] coef_const;
    logic            out_valid;
    logic [1:0]      out_ch;
    logic [PW-1:0]   out_data;
    logic            busy;

    rr_tdm_mult #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_CH(NC), .MULT_LATENCY(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coef_mode  (coef_mode),
        .coef_const (coef_const),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [PW-1:0] sb [NC][$];
    logic [CW-1:0] incr_m [NC];
    logic [CW-1:0] decr_m [NC];
    int            log_ch [$];
    int            log_t  [$];
    logic [PW-1:0] log_d  [$];
    logic [PW-1:0] last_data = '0;
    logic [PW-1:0] prev_data = '0;
    logic [1:0]    last_ch = '0;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        logic [7:0] cst;
        logic [7:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < NC; c++) n += sb[c].size();
        return n;
    endfunction

    // Reference model: coefficient chosen per channel in acceptance order.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                sb[c].delete();
                incr_m[c] = '0;
                decr_m[c] = '1;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    logic [1:0]    m;
                    logic [CW-1:0] cf;
                    m  = coef_mode[2*c +: 2];
                    cf = m == 2'd0 ? incr_m[c] : m == 2'd1 ? decr_m[c] : coef_const[c*CW +: CW];
                    sb[c].push_back(PW'(in_data[c*DW +: DW]) * PW'(cf));
                    if (m == 2'd0) incr_m[c] = incr_m[c] + 1'b1;
                    if (m == 2'd1) decr_m[c] = decr_m[c] - 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            log_ch.push_back(int'(out_ch));
            log_t.push_back(cyc);
            log_d.push_back(out_data);
            prev_data = last_data;
            last_data = out_data;
            last_ch   = out_ch;
            chk("out_expected", 32'(sb[out_ch].size() != 0), 1);
            if (sb[out_ch].size() != 0) chk("out_data", out_data, sb[out_ch].pop_front());
        end
    end

    task automatic clear_log();
        log_ch.delete();
        log_t.delete();
        log_d.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 600 && (busy || pending() != 0); i++) @(negedge clk);
        chk(nm, 32'(pending()) + 32'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int nz;
        tbl[0]  = '{0,  2'd0, 8'd0,   8'd3,   16'd0};
        tbl[1]  = '{0,  2'd0, 8'd0,   8'd3,   16'd3};
        tbl[2]  = '{0,  2'd0, 8'd0,   8'd3,   16'd6};
        tbl[3]  = '{0,  2'd2, 8'd7,   8'd3,   16'd21};
        tbl[4]  = '{0,  2'd2, 8'd7,   8'd5,   16'd35};
        tbl[5]  = '{0,  2'd0, 8'd0,   8'd3,   16'd9};
        tbl[6]  = '{0,  2'd0, 8'd0,   8'd3,   16'd12};
        tbl[7]  = '{2,  2'd2, 8'd255, 8'd255, 16'd65025};
        tbl[8]  = '{2,  2'd2, 8'd0,   8'd255, 16'd0};
        tbl[9]  = '{1,  2'd1, 8'd0,   8'd1,   16'd255};
        tbl[10] = '{1,  2'd1, 8'd0,   8'd2,   16'd508};
        tbl[11] = '{3,  2'd3, 8'd9,   8'd10,  16'd90};
        tbl[12] = '{1,  2'd0, 8'd0,   8'd4,   16'd0};

        in_valid = '0;
        in_data = '0;
        coef_mode = '0;
        coef_const = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'hF);

        // Lone channel 0, INCR, data 5: products 0,5,10 back to back, latency 5 edges.
        in_valid = 4'b0001;
        in_data[7:0] = 8'd5;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 3) in_valid = '0;
            if (out_valid) break;
        end
        chk("t1_latency", 32'(lat), 5);
        @(negedge clk);
        chk("t1_stream1", 32'(out_valid), 1);
        @(negedge clk);
        chk("t1_stream2", 32'(out_valid), 1);
        drain("t1_drain");
        chk("t1_last", 32'(last_data), 10);

        // All channels, CONST 2, data c+1.
        do_reset();
        coef_mode = 8'hAA;
        coef_const = {4{8'd2}};
        in_data = {8'd4, 8'd3, 8'd2, 8'd1};
        in_valid = 4'hF;
        repeat (20) @(negedge clk);
        in_valid = '0;
        drain("t2_drain");
        for (int i = 0; i < 12; i++) chk("t2_order", 32'(log_ch[i]), 32'(i % 4));
        for (int i = 0; i < 8; i++) chk("t2_data", 32'(log_d[i]), 32'((i % 4 + 1) * 2));

        // Channels 1 and 3, DECR, random data: strict alternation without gaps.
        do_reset();
        coef_mode = 8'h44;
        in_valid = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            in_data = $urandom;
            @(negedge clk);
        end
        in_valid = '0;
        drain("t3_drain");
        for (int i = 0; i < 12; i++) chk("t3_order", 32'(log_ch[i]), (i % 2) ? 32'd3 : 32'd1);
        for (int i = 1; i < 12; i++) chk("t3_gap", 32'(log_t[i] - log_t[i-1]), 1);

        // INCR wrap on channel 2 with data 1.
        do_reset();
        coef_mode = '0;
        in_data = {8'd0, 8'd1, 8'd0, 8'd0};
        in_valid = 4'b0100;
        repeat (257) @(negedge clk);
        in_valid = '0;
        drain("t4_drain");
        chk("t4_count", 32'(log_ch.size()), 257);
        chk("t4_before_wrap", 32'(prev_data), 255);
        chk("t4_after_wrap", 32'(last_data), 0);

        // Reset with holds full and products in flight.
        do_reset();
        coef_mode = '0;
        in_data = {8'd9, 8'd7, 8'd5, 8'd3};
        in_valid = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_ready_in_reset", 32'(in_ready), 0);
        @(negedge clk);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        in_valid = '0;
        clear_log();
        nz = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) nz++;
        end
        chk("t5_no_stale_out", 32'(nz), 0);
        in_valid = 4'hF;
        @(negedge clk);
        in_valid = '0;
        drain("t5_drain");
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", 32'(log_ch[i]), 32'(i));
            chk("t5_coef0", 32'(log_d[i]), 0);
        end

        // Single-shot vectors: mode switching, width extremes, CONST_ALT.
        do_reset();
        coef_mode = '0;
        for (int i = 0; i < 13; i++) begin
            coef_mode[2*tbl[i].ch +: 2] = tbl[i].mode;
            coef_const[tbl[i].ch*CW +: CW] = tbl[i].cst;
            in_data[tbl[i].ch*DW +: DW] = tbl[i].data;
            in_valid = '0;
            in_valid[tbl[i].ch] = 1'b1;
            @(negedge clk);
            in_valid = '0;
            drain("vec_drain");
            chk($sformatf("vec%0d_data", i), 32'(last_data), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_ch", i), 32'(last_ch), 32'(tbl[i].ch));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
